pwm_duty_slew: RTL

- Duty-cycle slew limiter between the SPI register file and the PWM generator.
- Consumes the SPI-written target duty byte and drives the duty byte the PWM generator uses.
- Ramps toward the target in programmable steps at a programmable rate, so SPI writes never cause abrupt duty jumps.
- Optional bypass gives immediate duty update.

---
 rtl/pwm_duty_slew.sv | 110 +++++++++++
 1 files changed

// File: rtl/pwm_duty_slew.sv
// Duty-cycle slew limiter: walks duty_out toward target_duty in steps of
// step_eff, one step every tick_div+1 cycles, so register writes never
// produce abrupt PWM duty jumps. bypass gives an immediate update.
module pwm_duty_slew #(
   parameter int DW = 8,
   parameter int PW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          bypass,
   input  logic [DW-1:0] target_duty,
   input  logic [3:0]    step,
   input  logic [PW-1:0] tick_div,
   output logic [DW-1:0] duty_out,
   output logic          ramping,
   output logic          at_target
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] RAMP_UP   = 2'd1;
   localparam logic [1:0] RAMP_DOWN = 2'd2;

   logic [1:0]    state;
   logic [PW-1:0] cnt;
   logic          tick;
   logic [DW:0]   step_eff;
   logic [DW:0]   duty_x;
   logic [DW:0]   tgt_x;
   logic [DW:0]   sum;
   logic [DW:0]   diff;
   logic [DW-1:0] nxt_duty;

   // Widened operands: the extra bit catches carry past full scale and
   // borrow below zero so the step never wraps.
   assign step_eff = (step == 4'd0) ? (DW+1)'(1) : {{(DW-3){1'b0}}, step};
   assign duty_x   = {1'b0, duty_out};
   assign tgt_x    = {1'b0, target_duty};
   assign sum      = duty_x + step_eff;
   assign diff     = duty_x - step_eff;
   assign tick     = (cnt == tick_div);

   // Next duty on a tick: one clamped step toward the current target.
   always_comb begin
      nxt_duty = duty_out;
      if (tgt_x > duty_x) begin
         nxt_duty = (sum > tgt_x) ? target_duty : sum[DW-1:0];
      end else if (tgt_x < duty_x) begin
         nxt_duty = (diff[DW] || (diff < tgt_x)) ? target_duty : diff[DW-1:0];
      end
   end

   // Ramp state machine, prescaler and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         duty_out  <= '0;
         state     <= IDLE;
         cnt       <= '0;
         ramping   <= 1'b0;
         at_target <= 1'b0;
      end else begin
         at_target <= 1'b0;
         if (bypass) begin
            duty_out <= target_duty;
            state    <= IDLE;
            cnt      <= '0;
            ramping  <= 1'b0;
         end else if (!en) begin
            state    <= IDLE;
            cnt      <= '0;
            ramping  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (tgt_x > duty_x) begin
                     state   <= RAMP_UP;
                     ramping <= 1'b1;
                  end else if (tgt_x < duty_x) begin
                     state   <= RAMP_DOWN;
                     ramping <= 1'b1;
                  end
               end
               default: begin
                  if (tick) begin
                     // Direction is re-decided here, so a target moved
                     // mid-ramp takes effect only on the next update.
                     cnt      <= '0;
                     duty_out <= nxt_duty;
                     if (nxt_duty == target_duty) begin
                        state     <= IDLE;
                        ramping   <= 1'b0;
                        at_target <= 1'b1;
                     end else if (tgt_x > duty_x) begin
                        state   <= RAMP_UP;
                        ramping <= 1'b1;
                     end else begin
                        state   <= RAMP_DOWN;
                        ramping <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule
